frame_buffer_dbl: RTL and testbench

- Parametrised, double-buffered successor to the single-bank GPU/VGA frame buffer.
- GPU renders into the back bank while the VGA adapter reads the front bank.
- A swap request is deferred until the next VGA frame start, so the display never tears.
- Optional clear engine fills the back bank with a constant colour, one pixel per cycle.

---
 rtl/frame_buffer_pkg.sv | 14 +
 rtl/fb_bank.sv | 38 +++
 rtl/frame_buffer_dbl.sv | 156 +++++++++++++++
 tb/tb_frame_buffer_dbl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared types and default geometry for the double-buffered frame buffer.
package frame_buffer_pkg;

  localparam int unsigned FB_H_RES   = 320;
  localparam int unsigned FB_V_RES   = 240;
  localparam int unsigned FB_PIXEL_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_bank.sv
// One pixel bank: synchronous write, registered read, out-of-range reads return 0.
module fb_bank #(
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned PIXEL_W = 4,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [PIXEL_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [PIXEL_W-1:0] rdata_o
);

  logic [PIXEL_W-1:0] mem_q [DEPTH];
  logic [PIXEL_W-1:0] rdata_q;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (32'(raddr_i) < DEPTH) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_dbl.sv
// Double-buffered frame buffer: GPU writes the back bank, VGA reads the front bank,
// swaps deferred to frame start. Clear engine built only with FRAME_BUFFER_DBL_CLEAR_EN.
module frame_buffer_dbl
  import frame_buffer_pkg::*;
#(
  parameter  int unsigned H_RES   = FB_H_RES,
  parameter  int unsigned V_RES   = FB_V_RES,
  parameter  int unsigned PIXEL_W = FB_PIXEL_W,
  localparam int unsigned DEPTH   = H_RES * V_RES,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic               gpu_clk,
  input  logic               gpu_rst,
  input  logic [PIXEL_W-1:0] gpu_pixel_data,
  input  logic [ADDR_W-1:0]  gpu_pixel_addr,
  input  logic               gpu_we,
  output logic               gpu_ready,
  input  logic               swap_req,
  output logic               swap_pending,
  input  logic               clear_req,
  input  logic [PIXEL_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               front_sel,
  input  logic               vga_frame_start,
  input  logic [ADDR_W-1:0]  vga_pixel_addr,
  output logic [PIXEL_W-1:0] vga_pixel_data
);

  fb_state_e          state_q;
  logic               front_sel_q;
  logic               gpu_ready_q;
  logic               swap_pending_q;
  logic               rd_sel_q;
  logic               wr_en_c;
  logic [ADDR_W-1:0]  wr_addr_c;
  logic [PIXEL_W-1:0] wr_data_c;
  logic [PIXEL_W-1:0] rd0_data;
  logic [PIXEL_W-1:0] rd1_data;

`ifdef FRAME_BUFFER_DBL_CLEAR_EN
  logic               clear_busy_q;
  logic [ADDR_W-1:0]  clr_cnt_q;
  logic [PIXEL_W-1:0] clr_color_q;
`else
  logic               unused_clear;
  assign unused_clear = ^{clear_req, clear_color};
`endif

  // Control FSM; all status outputs are registered alongside the state.
  always_ff @(posedge gpu_clk) begin
    if (gpu_rst) begin
      state_q        <= IDLE;
      front_sel_q    <= 1'b0;
      gpu_ready_q    <= 1'b1;
      swap_pending_q <= 1'b0;
      rd_sel_q       <= 1'b0;
`ifdef FRAME_BUFFER_DBL_CLEAR_EN
      clear_busy_q   <= 1'b0;
      clr_cnt_q      <= '0;
      clr_color_q    <= '0;
`endif
    end else begin
      rd_sel_q <= front_sel_q;
      unique case (state_q)
        IDLE: begin
`ifdef FRAME_BUFFER_DBL_CLEAR_EN
          if (clear_req) begin
            state_q      <= CLEAR;
            gpu_ready_q  <= 1'b0;
            clear_busy_q <= 1'b1;
            clr_cnt_q    <= '0;
            clr_color_q  <= clear_color;
          end else
`endif
          if (swap_req) begin
            state_q        <= SWAP_WAIT;
            gpu_ready_q    <= 1'b0;
            swap_pending_q <= 1'b1;
          end
        end
`ifdef FRAME_BUFFER_DBL_CLEAR_EN
        CLEAR: begin
          if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q      <= IDLE;
            gpu_ready_q  <= 1'b1;
            clear_busy_q <= 1'b0;
            clr_cnt_q    <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
`endif
        SWAP_WAIT: begin
          if (vga_frame_start) begin
            front_sel_q    <= ~front_sel_q;
            state_q        <= IDLE;
            gpu_ready_q    <= 1'b1;
            swap_pending_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          gpu_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Back-bank write port: clear engine owns it while clearing; reset blocks the edge write.
  always_comb begin
    wr_en_c   = gpu_we && gpu_ready_q;
    wr_addr_c = gpu_pixel_addr;
    wr_data_c = gpu_pixel_data;
`ifdef FRAME_BUFFER_DBL_CLEAR_EN
    if (state_q == CLEAR) begin
      wr_en_c   = 1'b1;
      wr_addr_c = clr_cnt_q;
      wr_data_c = clr_color_q;
    end
`endif
    if (gpu_rst) begin
      wr_en_c = 1'b0;
    end
  end

  fb_bank #(.DEPTH(DEPTH), .PIXEL_W(PIXEL_W)) u_bank0 (
    .clk_i   (gpu_clk),
    .rst_i   (gpu_rst),
    .we_i    (wr_en_c && front_sel_q),
    .waddr_i (wr_addr_c),
    .wdata_i (wr_data_c),
    .raddr_i (vga_pixel_addr),
    .rdata_o (rd0_data)
  );

  fb_bank #(.DEPTH(DEPTH), .PIXEL_W(PIXEL_W)) u_bank1 (
    .clk_i   (gpu_clk),
    .rst_i   (gpu_rst),
    .we_i    (wr_en_c && !front_sel_q),
    .waddr_i (wr_addr_c),
    .wdata_i (wr_data_c),
    .raddr_i (vga_pixel_addr),
    .rdata_o (rd1_data)
  );

  assign vga_pixel_data = rd_sel_q ? rd1_data : rd0_data;
  assign gpu_ready      = gpu_ready_q;
  assign swap_pending   = swap_pending_q;
  assign front_sel      = front_sel_q;
`ifdef FRAME_BUFFER_DBL_CLEAR_EN
  assign clear_busy     = clear_busy_q;
`else
  assign clear_busy     = 1'b0;
`endif

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Randomised bench for frame_buffer_dbl against a cycle-level reference model.
// Geometry is 4x5 so that out-of-range addresses exist on the 5-bit address ports.
module tb_frame_buffer_dbl;

  localparam int unsigned H_RES   = 4;
  localparam int unsigned V_RES   = 5;
  localparam int unsigned PIXEL_W = 4;
  localparam int unsigned DEPTH   = H_RES * V_RES;
  localparam int unsigned ADDR_W  = $clog2(DEPTH);
`ifdef FRAME_BUFFER_DBL_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic               gpu_clk = 1'b0;
  logic               gpu_rst;
  logic [PIXEL_W-1:0] gpu_pixel_data;
  logic [ADDR_W-1:0]  gpu_pixel_addr;
  logic               gpu_we;
  logic               gpu_ready;
  logic               swap_req;
  logic               swap_pending;
  logic               clear_req;
  logic [PIXEL_W-1:0] clear_color;
  logic               clear_busy;
  logic               front_sel;
  logic               vga_frame_start;
  logic [ADDR_W-1:0]  vga_pixel_addr;
  logic [PIXEL_W-1:0] vga_pixel_data;

  frame_buffer_dbl #(.H_RES(H_RES), .V_RES(V_RES), .PIXEL_W(PIXEL_W)) dut (
    .gpu_clk         (gpu_clk),
    .gpu_rst         (gpu_rst),
    .gpu_pixel_data  (gpu_pixel_data),
    .gpu_pixel_addr  (gpu_pixel_addr),
    .gpu_we          (gpu_we),
    .gpu_ready       (gpu_ready),
    .swap_req        (swap_req),
    .swap_pending    (swap_pending),
    .clear_req       (clear_req),
    .clear_color     (clear_color),
    .clear_busy      (clear_busy),
    .front_sel       (front_sel),
    .vga_frame_start (vga_frame_start),
    .vga_pixel_addr  (vga_pixel_addr),
    .vga_pixel_data  (vga_pixel_data)
  );

  always #5 gpu_clk = ~gpu_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: pixel arrays plus "clear pixels remaining" and "swap waiting".
  int unsigned mbank [2][DEPTH];
  int unsigned m_front      = 0;
  int unsigned m_clear_left = 0;
  int unsigned m_color      = 0;
  bit          m_swap_wait  = 1'b0;
  int unsigned m_rd         = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int unsigned back;
    if (gpu_rst) begin
      m_front      = 0;
      m_clear_left = 0;
      m_swap_wait  = 1'b0;
      m_rd         = 0;
    end else begin
      back = 1 - m_front;
      m_rd = (int'(vga_pixel_addr) < DEPTH) ? mbank[m_front][vga_pixel_addr] : 0;
      if (m_clear_left > 0) begin
        mbank[back][DEPTH - m_clear_left] = m_color;
        m_clear_left--;
      end else if (m_swap_wait) begin
        if (vga_frame_start) begin
          m_front     = back;
          m_swap_wait = 1'b0;
        end
      end else begin
        if (gpu_we && int'(gpu_pixel_addr) < DEPTH) mbank[back][gpu_pixel_addr] = gpu_pixel_data;
        if (CLEAR_EN && clear_req) begin
          m_clear_left = DEPTH;
          m_color      = clear_color;
        end else if (swap_req) begin
          m_swap_wait = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge gpu_clk);
    #1;
    check_eq("gpu_ready",      32'(gpu_ready),      32'((m_clear_left == 0) && !m_swap_wait));
    check_eq("swap_pending",   32'(swap_pending),   32'(m_swap_wait));
    check_eq("clear_busy",     32'(clear_busy),     32'(m_clear_left > 0));
    check_eq("front_sel",      32'(front_sel),      m_front);
    check_eq("vga_pixel_data", 32'(vga_pixel_data), m_rd);
  endtask

  task automatic idle_inputs();
    gpu_we          = 1'b0;
    swap_req        = 1'b0;
    clear_req       = 1'b0;
    vga_frame_start = 1'b0;
  endtask

  task automatic write_px(input int unsigned a, input int unsigned d);
    gpu_pixel_addr = ADDR_W'(a);
    gpu_pixel_data = PIXEL_W'(d);
    gpu_we         = 1'b1;
    step();
    gpu_we         = 1'b0;
  endtask

  task automatic do_swap(input int unsigned gap);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    repeat (gap) step();
    vga_frame_start = 1'b1;
    step();
    vga_frame_start = 1'b0;
    step();
  endtask

  task automatic read_all();
    for (int a = 0; a < 32; a++) begin
      vga_pixel_addr = ADDR_W'(a);
      step();
    end
    step();
  endtask

  initial begin
    idle_inputs();
    gpu_rst        = 1'b1;
    gpu_pixel_addr = ADDR_W'(5);
    gpu_pixel_data = '0;
    clear_color    = '0;
    vga_pixel_addr = ADDR_W'(5);
    step();
    step();
    gpu_rst = 1'b0;

    // Fill both banks with known data; keep reads out of range meanwhile.
    vga_pixel_addr = ADDR_W'(31);
    for (int a = 0; a < int'(DEPTH); a++) write_px(a, $urandom_range(0, 9));
    do_swap(3);
    for (int a = 0; a < int'(DEPTH); a++) write_px(a, $urandom_range(0, 9));
    do_swap(3);

    // Write to back bank is invisible until the swap.
    write_px(5, 'hA);
    vga_pixel_addr = ADDR_W'(5);
    step();
    step();
    do_swap(10);
    step();
    step();

    // Clear with GPU writes hammering during the clear.
    clear_color = PIXEL_W'(3);
    clear_req   = 1'b1;
    step();
    clear_req   = 1'b0;
    clear_color = PIXEL_W'($urandom);
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      gpu_we         = 1'b1;
      gpu_pixel_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      gpu_pixel_data = PIXEL_W'($urandom);
      step();
    end
    gpu_we = 1'b0;
    do_swap(2);
    read_all();

    // Clear and swap in the same cycle.
    clear_color = PIXEL_W'(9);
    clear_req   = 1'b1;
    swap_req    = 1'b1;
    step();
    idle_inputs();
    repeat (DEPTH + 3) step();
    vga_frame_start = 1'b1;
    step();
    vga_frame_start = 1'b0;
    step();

    // Out-of-range writes and reads.
    write_px(DEPTH, 7);
    write_px(31, 7);
    do_swap(1);
    read_all();

    // Reset in the ninth cycle of a clear.
    clear_color = PIXEL_W'(5);
    clear_req   = 1'b1;
    step();
    clear_req   = 1'b0;
    repeat (8) step();
    gpu_rst = 1'b1;
    step();
    gpu_rst = 1'b0;
    step();
    read_all();
    do_swap(1);
    read_all();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      gpu_we          = ($urandom_range(0, 1) == 1);
      gpu_pixel_addr  = ADDR_W'($urandom);
      gpu_pixel_data  = PIXEL_W'($urandom);
      swap_req        = ($urandom_range(0, 7) == 0);
      clear_req       = ($urandom_range(0, 15) == 0);
      clear_color     = PIXEL_W'($urandom);
      vga_frame_start = ($urandom_range(0, 9) == 0);
      vga_pixel_addr  = ADDR_W'($urandom);
      gpu_rst         = ($urandom_range(0, 99) == 0);
      step();
    end
    idle_inputs();
    gpu_rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
